reset_sequencer: RTL and testbench

//  Owns board bring-up after the clock generator. Watches the DCM/PLL lock, waits for
//  the lock to stay stable, then releases NSTAGES active-high block resets one at a time.

---
 rtl/reset_sequencer_pkg.sv | 23 ++
 rtl/reset_sequencer_sync_2ff.sv | 24 ++
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding, default timing constants and sizing helper for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SOFT      = 3'd4
  } state_t;

  localparam int DEF_NSTAGES   = 3;
  localparam int DEF_LOCK_WAIT = 31;
  localparam int DEF_STAGE_GAP = 8;
  localparam int DEF_SOFT_HOLD = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; cleared to 0 by reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Waits for a stable PLL lock, then releases staged active-high resets one by one;
// also runs a soft-reset request/ack cycle. All outputs are registered.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NSTAGES   = DEF_NSTAGES,
  parameter int LOCK_WAIT = DEF_LOCK_WAIT,
  parameter int STAGE_GAP = DEF_STAGE_GAP,
  parameter int SOFT_HOLD = DEF_SOFT_HOLD
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               lock_i,
  input  logic               soft_req,
  output logic               soft_ack,
  output logic [NSTAGES-1:0] rst_o,
  output logic               ready
);

  localparam int CNT_W = $clog2(max3(LOCK_WAIT, STAGE_GAP, SOFT_HOLD) + 1);
  localparam int STG_W = $clog2(NSTAGES + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [STG_W-1:0]   r_stage;
  logic [NSTAGES-1:0] r_rst_o;
  logic               r_ready;
  logic               r_soft_ack;
  logic               r_soft_pend;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [STG_W-1:0]   w_stage_nxt;
  logic [NSTAGES-1:0] w_rst_nxt;
  logic               w_ready_nxt;
  logic               w_ack_nxt;
  logic               w_pend_nxt;
  logic               w_lock_s;

  sync_2ff u_lock_sync (
    .clk  (clk),
    .rst_ (rst_),
    .d    (lock_i),
    .q    (w_lock_s)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_rst_o     <= '1;
      r_ready     <= 1'b0;
      r_soft_ack  <= 1'b0;
      r_soft_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stage     <= w_stage_nxt;
      r_rst_o     <= w_rst_nxt;
      r_ready     <= w_ready_nxt;
      r_soft_ack  <= w_ack_nxt;
      r_soft_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_rst_nxt   = r_rst_o;
    w_ready_nxt = 1'b0;
    w_ack_nxt   = 1'b0;
    w_pend_nxt  = r_soft_pend;

    // Lock loss outranks everything, including a soft request or a stage release.
    if (r_state != WAIT_LOCK && !w_lock_s) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
      w_rst_nxt   = '1;
      w_pend_nxt  = 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_cnt_nxt = '0;
          w_rst_nxt = '1;
          if (w_lock_s) w_state_nxt = STABLE;
        end
        STABLE: begin
          if (r_cnt == CNT_W'(LOCK_WAIT - 1)) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == '0 && r_stage == STG_W'(NSTAGES)) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
            w_ack_nxt   = r_soft_pend;
            w_pend_nxt  = 1'b0;
          end else begin
            if (r_cnt == '0) begin
              for (int k = 0; k < NSTAGES; k++) begin
                if (r_stage == STG_W'(k)) w_rst_nxt[k] = 1'b0;
              end
            end
            if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
              w_cnt_nxt   = '0;
              w_stage_nxt = r_stage + STG_W'(1);
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (soft_req) begin
            w_state_nxt = SOFT;
            w_cnt_nxt   = '0;
            w_rst_nxt   = '1;
            w_pend_nxt  = 1'b1;
          end else begin
            w_ready_nxt = 1'b1;
          end
        end
        SOFT: begin
          if (r_cnt == CNT_W'(SOFT_HOLD - 1)) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_rst_nxt   = '1;
        end
      endcase
    end
  end

  assign rst_o    = r_rst_o;
  assign ready    = r_ready;
  assign soft_ack = r_soft_ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed bring-up/soft/lock-loss/async-reset scenarios, then random traffic.
module tb_reset_sequencer;

  localparam int NS  = 3;
  localparam int LW  = 31;
  localparam int GAP = 8;
  localparam int SH  = 16;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          lock_i = 1'b0;
  logic          soft_req = 1'b0;
  logic          soft_ack;
  logic [NS-1:0] rst_o;
  logic          ready;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NSTAGES   (NS),
    .LOCK_WAIT (LW),
    .STAGE_GAP (GAP),
    .SOFT_HOLD (SH)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .lock_i   (lock_i),
    .soft_req (soft_req),
    .soft_ack (soft_ack),
    .rst_o    (rst_o),
    .ready    (ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a timeline measured from the edge a sequence starts (boot or soft),
  // with every output a plain function of the elapsed edge count.
  bit m_s1, m_s2, m_active, m_soft;
  int m_n, m_d;

  function automatic int run_at();
    return m_d + 1 + NS * GAP;
  endfunction

  function automatic logic [NS-1:0] exp_rst();
    logic [NS-1:0] r;
    r = '1;
    if (m_active)
      for (int k = 0; k < NS; k++)
        if (m_n >= m_d + 1 + k * GAP) r[k] = 1'b0;
    return r;
  endfunction

  function automatic logic exp_ready();
    return m_active && (m_n >= run_at());
  endfunction

  function automatic logic exp_ack();
    return m_active && m_soft && (m_n == run_at());
  endfunction

  function automatic logic mono_ok(input logic [NS-1:0] r);
    logic ok;
    ok = 1'b1;
    for (int k = 1; k < NS; k++)
      if (!r[k] && r[k-1]) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_active = 0; m_soft = 0; m_n = 0; m_d = LW;
  endtask

  task automatic model_edge();
    bit lk;
    bit in_run;
    lk     = m_s2;
    in_run = exp_ready();
    m_s2   = m_s1;
    m_s1   = lock_i;
    if (!m_active) begin
      if (lk) begin m_active = 1; m_n = 0; m_d = LW; m_soft = 0; end
    end else if (!lk) begin
      m_active = 0;
    end else if (in_run && soft_req) begin
      m_n = 0; m_d = SH; m_soft = 1;
    end else if (m_n < 100000) begin
      m_n++;
    end
  endtask

  task automatic compare();
    check("rst_o", 32'(rst_o), 32'(exp_rst()));
    check("ready", 32'(ready), 32'(exp_ready()));
    check("soft_ack", 32'(soft_ack), 32'(exp_ack()));
    check("monotonic", 32'(mono_ok(rst_o)), 32'd1);
    check("ready_implies_clear", 32'(!ready || (rst_o == '0)), 32'd1);
    if (soft_ack === 1'b1) n_acks++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_) model_edge(); else model_reset();
    @(negedge clk);
    compare();
  endtask

  // Runs n edges from edge 0 and reports the first edge each bit fell and ready rose.
  task automatic run_track(input int n, output int f0, output int f1, output int f2, output int fr);
    f0 = -1; f1 = -1; f2 = -1; fr = -1;
    for (int e = 0; e < n; e++) begin
      step();
      if (f0 < 0 && rst_o[0] === 1'b0) f0 = e;
      if (f1 < 0 && rst_o[1] === 1'b0) f1 = e;
      if (f2 < 0 && rst_o[2] === 1'b0) f2 = e;
      if (fr < 0 && ready === 1'b1) fr = e;
    end
  endtask

  task automatic do_reset();
    rst_ = 1'b0; lock_i = 1'b0; soft_req = 1'b0;
    model_reset();
    repeat (3) step();
    rst_ = 1'b1;
  endtask

  initial begin
    int f0, f1, f2, fr;
    int drop_left, sr_left;
    bit found;

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rst_o", 32'(rst_o), 32'h7);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_ack", 32'(soft_ack), 32'd0);
    rst_ = 1'b1;

    // Clean bring-up
    lock_i = 1'b1;
    run_track(62, f0, f1, f2, fr);
    check("t1_fall0", 32'(f0), 32'd34);
    check("t1_fall1", 32'(f1), 32'd42);
    check("t1_fall2", 32'(f2), 32'd50);
    check("t1_ready", 32'(fr), 32'd58);

    // One-cycle lock glitch while counting
    do_reset();
    lock_i = 1'b1;
    f0 = -1; fr = -1;
    for (int e = 0; e < 86; e++) begin
      lock_i = (e == 20) ? 1'b0 : 1'b1;
      step();
      if (f0 < 0 && rst_o[0] === 1'b0) f0 = e;
      if (fr < 0 && ready === 1'b1) fr = e;
    end
    check("t2_fall0", 32'(f0), 32'd55);
    check("t2_ready", 32'(fr), 32'd79);

    // Soft reset pulse from RUN
    n_acks = 0;
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    check("t3_all_set", 32'(rst_o), 32'h7);
    check("t3_not_ready", 32'(ready), 32'd0);
    f0 = -1; f1 = -1; f2 = -1; fr = -1;
    for (int r = 1; r <= 45; r++) begin
      step();
      if (f0 < 0 && rst_o[0] === 1'b0) f0 = r;
      if (f1 < 0 && rst_o[1] === 1'b0) f1 = r;
      if (f2 < 0 && rst_o[2] === 1'b0) f2 = r;
      if (fr < 0 && ready === 1'b1) fr = r;
    end
    check("t3_fall0", 32'(f0), 32'd17);
    check("t3_fall1", 32'(f1), 32'd25);
    check("t3_fall2", 32'(f2), 32'd33);
    check("t3_ready", 32'(fr), 32'd41);
    check("t3_acks", 32'(n_acks), 32'd1);

    // Soft request in the same cycle the synced lock is lost
    n_acks = 0;
    lock_i = 1'b0;
    step();
    step();
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    check("t4_all_set", 32'(rst_o), 32'h7);
    check("t4_not_ready", 32'(ready), 32'd0);
    repeat (4) step();
    lock_i = 1'b1;
    run_track(62, f0, f1, f2, fr);
    check("t4_fall0", 32'(f0), 32'd34);
    check("t4_ready", 32'(fr), 32'd58);
    check("t4_no_ack", 32'(n_acks), 32'd0);

    // Asynchronous reset in the middle of staging
    do_reset();
    lock_i = 1'b1;
    found = 0;
    for (int e = 0; e < 100 && !found; e++) begin
      step();
      if (rst_o === 3'b100) found = 1;
    end
    check("t5_reach_stage1", 32'(found), 32'd1);
    #2;
    rst_ = 1'b0;
    #1;
    check("t5_async_rst_o", 32'(rst_o), 32'h7);
    check("t5_async_ready", 32'(ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_ = 1'b1;

    // Random lock glitches and soft requests
    drop_left = 0; sr_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (drop_left > 0) begin
        lock_i = 1'b0; drop_left--;
      end else begin
        lock_i = 1'b1;
        if ($urandom_range(0, 299) == 0) drop_left = $urandom_range(1, 4);
      end
      if (sr_left > 0) begin
        soft_req = 1'b1; sr_left--;
      end else begin
        soft_req = 1'b0;
        if ($urandom_range(0, 19) == 0) sr_left = $urandom_range(1, 60);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
